irs2_readout_ctrl: RTL and testbench



---
 rtl/irs2_readout_pkg.sv | 33 +++
 rtl/irs2_next_ch.sv | 26 ++
 rtl/irs2_readout_ctrl.sv | 146 ++++++++++++++
 tb/tb_irs2_readout_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irs2_readout_pkg.sv
// Shared types and field layout for the IRS2 readout sequencer.
package irs2_readout_pkg;

    localparam int CH_W      = 3;
    localparam int SMP_W     = 6;
    localparam int DAT_W     = 12;
    localparam int WORD_W    = 16;
    localparam int FIRST_BIT = 15;
    localparam int CH_LSB    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LATCH,
        ST_PUSH,
        ST_DONE
    } state_t;

    // Output word layout: {first, ch, data}.
    function automatic logic [WORD_W-1:0] make_word(
        input logic             first,
        input logic [CH_W-1:0]  ch,
        input logic [DAT_W-1:0] data
    );
        logic [WORD_W-1:0] w;
        w                       = '0;
        w[FIRST_BIT]            = first;
        w[CH_LSB +: CH_W]       = ch;
        w[DAT_W-1:0]            = data;
        return w;
    endfunction

endpackage

// File: rtl/irs2_next_ch.sv
// Priority finder: lowest enabled channel above (or, when inclusive, at) base.
module irs2_next_ch
    import irs2_readout_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   base,
    input  logic              inclusive,
    output logic [CH_W-1:0]   next_ch,
    output logic              none
);

    // Scan downward so the lowest qualifying channel is the last one written.
    always_comb begin
        next_ch = '0;
        none    = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(base)) || (inclusive && (i == int'(base))))) begin
                next_ch = CH_W'(i);
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irs2_readout_ctrl.sv
// IRS2 readout sequencer: steps SMP/CH over enabled channels, captures DAT, streams tagged words.
// Optional test-pattern data source is enabled by defining IRS2_READOUT_TEST_PATTERN_EN.
module irs2_readout_ctrl
    import irs2_readout_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int NUM_SMP = 64,
    parameter int SETTLE  = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
`ifdef IRS2_READOUT_TEST_PATTERN_EN
    input  logic              tp_en_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [SMP_W-1:0]  smp_o,
    output logic [CH_W-1:0]   ch_o,
    input  logic [DAT_W-1:0]  dat_i,
    output logic [WORD_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q;
    logic [3:0]          settle_q;
    logic                enter_setup, capture, advance;
    logic                handshake, last_smp;
    logic [NUM_CH-1:0]   fnd_mask;
    logic [CH_W-1:0]     fnd_base, fnd_ch;
    logic                fnd_incl, fnd_none;
    logic [DAT_W-1:0]    data_sel;

    // In IDLE the finder looks at the incoming mask from channel 0; otherwise strictly above ch_o.
    assign fnd_mask  = (state_q == ST_IDLE) ? ch_mask_i : mask_q;
    assign fnd_base  = (state_q == ST_IDLE) ? '0 : ch_o;
    assign fnd_incl  = (state_q == ST_IDLE);
    assign handshake = dout_valid_o && dout_ready_i;
    assign last_smp  = (smp_o == SMP_W'(NUM_SMP - 1));

    irs2_next_ch #(.NUM_CH(NUM_CH)) u_next_ch (
        .mask      (fnd_mask),
        .base      (fnd_base),
        .inclusive (fnd_incl),
        .next_ch   (fnd_ch),
        .none      (fnd_none)
    );

`ifdef IRS2_READOUT_TEST_PATTERN_EN
    logic tp_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          tp_q <= 1'b0;
        else if (state_q == ST_IDLE && start_i) tp_q <= tp_en_i;
    end

    assign data_sel = tp_q ? {ch_o, 3'b000, smp_o} : dat_i;
`else
    assign data_sel = dat_i;
`endif

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        enter_setup = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = fnd_none ? ST_DONE : ST_SETUP;
            ST_SETUP: if (settle_q == '0) begin
                          state_d = ST_LATCH;
                          capture = 1'b1;
                      end
            ST_LATCH: state_d = ST_PUSH;
            ST_PUSH:  if (handshake) begin
                          advance = 1'b1;
                          state_d = (last_smp && fnd_none) ? ST_DONE : ST_SETUP;
                      end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Abort wins over a simultaneous handshake: the word is not consumed.
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            capture = 1'b0;
            advance = 1'b0;
        end
        enter_setup = (state_d == ST_SETUP) && (state_q != ST_SETUP);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            dout_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_o       <= (state_d == ST_SETUP) || (state_d == ST_LATCH) || (state_d == ST_PUSH);
            done_o       <= (state_d == ST_DONE);
            dout_valid_o <= (state_d == ST_PUSH);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mask_q      <= '0;
            settle_q    <= '0;
            smp_o       <= '0;
            ch_o        <= '0;
            dout_o      <= '0;
            dout_last_o <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start_i) mask_q <= ch_mask_i;

            if (enter_setup)                                settle_q <= SETTLE_INIT;
            else if (state_q == ST_SETUP && settle_q != '0) settle_q <= settle_q - 1'b1;

            if (state_q == ST_IDLE && enter_setup) begin
                smp_o <= '0;
                ch_o  <= fnd_ch;
            end else if (advance) begin
                if (!last_smp) begin
                    smp_o <= smp_o + 1'b1;
                end else if (!fnd_none) begin
                    smp_o <= '0;
                    ch_o  <= fnd_ch;
                end
            end

            if (capture) begin
                dout_o      <= make_word(smp_o == '0, ch_o, data_sel);
                dout_last_o <= last_smp && fnd_none;
            end
        end
    end

endmodule

// File: tb/tb_irs2_readout_ctrl.sv
// Directed self-checking bench for irs2_readout_ctrl; the IRS2 model presents valid DAT
// only in the single cycle that is sampled SETTLE edges after an address change.
module tb_irs2_readout_ctrl;

    localparam int SETTLE  = 3;
    localparam int NUM_SMP = 64;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  ch_mask_i;
`ifdef IRS2_READOUT_TEST_PATTERN_EN
    logic        tp_en_i;
`endif
    logic        busy_o;
    logic        done_o;
    logic [5:0]  smp_o;
    logic [2:0]  ch_o;
    logic [11:0] dat_i;
    logic [15:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i;
    logic        dout_last_o;

    always #5 clk = ~clk;

    irs2_readout_ctrl #(.NUM_CH(8), .NUM_SMP(NUM_SMP), .SETTLE(SETTLE)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .ch_mask_i    (ch_mask_i),
`ifdef IRS2_READOUT_TEST_PATTERN_EN
        .tp_en_i      (tp_en_i),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .smp_o        (smp_o),
        .ch_o         (ch_o),
        .dat_i        (dat_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .dout_last_o  (dout_last_o)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] words[$];
    bit          lasts[$];
    int          hs_cyc[$];
    int          done_cnt, done_cyc, unstable, age;
    bit          busy_seen, ch6_seen, timed_out, post_busy, post_valid;
    logic [5:0]  prev_smp;
    logic [2:0]  prev_ch;
    logic        prev_busy;

    function automatic logic [15:0] exp_word(input int ch, input int smp, input bit tp);
        logic [11:0] d;
        d = tp ? 12'((ch << 9) | smp) : 12'(smp * 3);
        return {(smp == 0), 3'(ch), d};
    endfunction

    // Index of first word differing from the model, or -1.
    function automatic int first_bad(input int ch_a, input int ch_b, input bit tp);
        for (int i = 0; i < words.size(); i++) begin
            if (words[i] !== exp_word((i < NUM_SMP) ? ch_a : ch_b, i % NUM_SMP, tp)) return i;
        end
        return -1;
    endfunction

    // One clock; afterwards update the DAT model from the address it now sees.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (smp_o !== prev_smp || ch_o !== prev_ch || (busy_o && !prev_busy)) age = 0;
        else if (age < 1000) age++;
        prev_smp  = smp_o;
        prev_ch   = ch_o;
        prev_busy = busy_o;
        dat_i = (age == SETTLE - 1) ? 12'(int'(smp_o) * 3) : 12'hEEE;
    endtask

    task automatic run_block(input logic [7:0] mask, input int ready_mode,
                             input int abort_at, input int restart_at);
        int          tail;
        bit          ending, aborted, prev_stall, prev_last;
        logic [15:0] prev_dout;
        words.delete(); lasts.delete(); hs_cyc.delete();
        done_cnt = 0; done_cyc = -1; unstable = 0;
        busy_seen = 0; ch6_seen = 0; timed_out = 1; post_busy = 0; post_valid = 0;
        tail = 0; ending = 0; aborted = 0; prev_stall = 0; prev_last = 0; prev_dout = '0;
        ch_mask_i = mask;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        ch_mask_i = 8'hFF;
        for (int c = 0; c < 3000; c++) begin
            if (aborted && abort_i) begin
                abort_i    = 1'b0;
                post_busy  = busy_o;
                post_valid = dout_valid_o;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy_o) busy_seen = 1;
            if (busy_o && ch_o == 3'd6) ch6_seen = 1;
            if (prev_stall && (!dout_valid_o || dout_o !== prev_dout || dout_last_o !== prev_last))
                unstable++;
            if (ending) begin
                tail++;
                if (tail >= 4) begin
                    timed_out = 0;
                    break;
                end
            end else if (done_cnt > 0 || aborted) begin
                ending = 1;
            end
            dout_ready_i = (ready_mode == 0) ? 1'b1 : ((c % 4) == 3);
            start_i      = (c == restart_at);
            if (!aborted && abort_at >= 0 && dout_valid_o && dout_ready_i && words.size() == abort_at) begin
                abort_i = 1'b1;
                aborted = 1;
            end
            if (dout_valid_o && dout_ready_i && !abort_i) begin
                words.push_back(dout_o);
                lasts.push_back(dout_last_o);
                hs_cyc.push_back(c);
            end
            prev_stall = dout_valid_o && !dout_ready_i;
            prev_dout  = dout_o;
            prev_last  = dout_last_o;
            step();
        end
        start_i      = 1'b0;
        abort_i      = 1'b0;
        dout_ready_i = 1'b1;
        tests++;
        if (timed_out) begin
            fails++;
            $display("FAIL block_timeout: mask %h did not finish within budget", mask);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; ch_mask_i = '0;
        dat_i = '0; dout_ready_i = 1'b1;
`ifdef IRS2_READOUT_TEST_PATTERN_EN
        tp_en_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (busy_o !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests++; if (done_o !== 1'b0)       begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
        tests++; if (smp_o !== 6'd0)        begin fails++; $display("FAIL reset_smp: got %h want 0", smp_o); end
        tests++; if (ch_o !== 3'd0)         begin fails++; $display("FAIL reset_ch: got %h want 0", ch_o); end
        tests++; if (dout_o !== 16'h0000)   begin fails++; $display("FAIL reset_dout: got %h want 0000", dout_o); end
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dout_valid_o); end
        tests++; if (dout_last_o !== 1'b0)  begin fails++; $display("FAIL reset_last: got %b want 0", dout_last_o); end
        rst_n_i = 1'b1;
        prev_smp = smp_o; prev_ch = ch_o; prev_busy = busy_o; age = 0;
        step();
    endtask

    task automatic test_single_ch();
        int bad, nlast, gap_bad;
        run_block(8'h01, 0, -1, -1);
        tests++; if (words.size() != 64) begin fails++; $display("FAIL single_count: got %0d want 64", words.size()); end
        if (words.size() == 64) begin
            tests++; if (words[0] !== 16'h8000)  begin fails++; $display("FAIL single_first: got %h want 8000", words[0]); end
            tests++; if (words[63] !== 16'h00BD) begin fails++; $display("FAIL single_lastword: got %h want 00BD", words[63]); end
            tests++; if (lasts[63] !== 1'b1)     begin fails++; $display("FAIL single_lastflag: got %b want 1", lasts[63]); end
            tests++; if (hs_cyc[0] != SETTLE + 1) begin fails++; $display("FAIL single_latency: got %0d want %0d", hs_cyc[0], SETTLE + 1); end
        end
        nlast = 0;
        foreach (lasts[i]) if (lasts[i]) nlast++;
        tests++; if (nlast != 1) begin fails++; $display("FAIL single_lastcount: got %0d want 1", nlast); end
        bad = first_bad(0, 0, 0);
        tests++; if (bad >= 0) begin fails++; $display("FAIL single_data: word %0d got %h want %h", bad, words[bad], exp_word(0, bad, 0)); end
        gap_bad = 0;
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != SETTLE + 2) gap_bad++;
        tests++; if (gap_bad != 0) begin fails++; $display("FAIL single_throughput: got %0d bad gaps want 0", gap_bad); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_two_ch();
        int bad, nfirst, nlast;
        run_block(8'hA0, 0, -1, 50);
        tests++; if (words.size() != 128) begin fails++; $display("FAIL two_count: got %0d want 128", words.size()); end
        nfirst = 0; nlast = 0;
        foreach (words[i]) if (words[i][15] && (i == 0 || i == 64)) nfirst++; else if (words[i][15]) nfirst += 100;
        foreach (lasts[i]) if (lasts[i]) nlast++;
        tests++; if (nfirst != 2) begin fails++; $display("FAIL two_first_bits: got code %0d want 2", nfirst); end
        tests++; if (nlast != 1 || lasts.size() != 128 || !lasts[127]) begin fails++; $display("FAIL two_last: got %0d flags want 1 on word 127", nlast); end
        bad = first_bad(5, 7, 0);
        tests++; if (bad >= 0) begin fails++; $display("FAIL two_data: word %0d got %h want %h", bad, words[bad], exp_word((bad < 64) ? 5 : 7, bad % 64, 0)); end
        tests++; if (ch6_seen) begin fails++; $display("FAIL two_ch6: got ch_o=6 seen want never"); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL two_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int bad;
        run_block(8'h01, 1, -1, -1);
        tests++; if (words.size() != 64) begin fails++; $display("FAIL bp_count: got %0d want 64", words.size()); end
        tests++; if (unstable != 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable); end
        bad = first_bad(0, 0, 0);
        tests++; if (bad >= 0) begin fails++; $display("FAIL bp_data: word %0d got %h want %h", bad, words[bad], exp_word(0, bad, 0)); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_abort();
        run_block(8'h01, 0, 10, -1);
        tests++; if (words.size() != 10) begin fails++; $display("FAIL abort_count: got %0d want 10", words.size()); end
        tests++; if (post_busy !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b want 0", post_busy); end
        tests++; if (post_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", post_valid); end
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        run_block(8'h01, 0, -1, -1);
        tests++; if (words.size() != 64) begin fails++; $display("FAIL restart_count: got %0d want 64", words.size()); end
        if (words.size() > 0) begin
            tests++; if (words[0] !== 16'h8000) begin fails++; $display("FAIL restart_first: got %h want 8000", words[0]); end
        end
    endtask

    task automatic test_zero_mask();
        run_block(8'h00, 0, -1, -1);
        tests++; if (done_cyc != 0) begin fails++; $display("FAIL zero_done_time: got cycle %0d want 0", done_cyc); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        tests++; if (words.size() != 0) begin fails++; $display("FAIL zero_words: got %0d want 0", words.size()); end
        tests++; if (busy_seen) begin fails++; $display("FAIL zero_busy: got busy high want never"); end
    endtask

`ifdef IRS2_READOUT_TEST_PATTERN_EN
    task automatic test_pattern();
        tp_en_i = 1'b1;
        run_block(8'h04, 0, -1, -1);
        tp_en_i = 1'b0;
        tests++; if (words.size() != 64) begin fails++; $display("FAIL tp_count: got %0d want 64", words.size()); end
        if (words.size() == 64) begin
            tests++; if (words[0] !== 16'hA400)  begin fails++; $display("FAIL tp_first: got %h want A400", words[0]); end
            tests++; if (words[37] !== 16'h2425) begin fails++; $display("FAIL tp_smp37: got %h want 2425", words[37]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_ch();
        test_two_ch();
        test_backpressure();
        test_abort();
        test_zero_mask();
`ifdef IRS2_READOUT_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
